// File: rtl/sa_ram_rws_arb_ctrl.sv
// sa_ram_rws_arb_ctrl: shares one separate-read/write-port SA RAM (registered
// read address, combinational read data) between two read and two write
// requesters. Each port class has its own round-robin arbiter, so a read and
// a write can both be granted in the same cycle.
// Optional build macro: SA_RAM_ARB_PERF_EN adds saturating read/write/stall
// performance counters.
module sa_ram_rws_arb_ctrl #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd0_req,
    input  logic [AW-1:0] rd0_addr,
    output logic          rd0_gnt,
    input  logic          rd1_req,
    input  logic [AW-1:0] rd1_addr,
    output logic          rd1_gnt,
    input  logic          wr0_req,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_gnt,
    input  logic          wr1_req,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_gnt,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
`ifdef SA_RAM_ARB_PERF_EN
    output logic [31:0]   perf_rd_cnt,
    output logic [31:0]   perf_wr_cnt,
    output logic [31:0]   perf_stall_cnt,
`endif
    input  logic [DW-1:0] ram_dout
);

    logic          rd_ptr;
    logic          wr_ptr;
    logic [AW-1:0] hold_addr;
    logic          stall;
    logic          rd_en;
    logic          rd_el0, rd_el1;
    logic          wr_blk0, wr_blk1;
    logic          wr_el0, wr_el1;

    // Response data comes straight from the RAM; ra_d holds it during a stall.
    assign rsp_data = ram_dout;

    // Read and write round-robin arbitration plus RAM port muxing.
    always_comb begin
        stall   = rsp_vld & ~rsp_rdy;
        rd_en   = ~stall & ~rst;
        rd_el0  = rd0_req & rd_en;
        rd_el1  = rd1_req & rd_en;
        rd0_gnt = rd_el0 & (~rd_el1 | ~rd_ptr);
        rd1_gnt = rd_el1 & (~rd_el0 | rd_ptr);
        ram_re  = rd0_gnt | rd1_gnt;
        ram_ra  = rd1_gnt ? rd1_addr : rd0_addr;

        // A write must not disturb the address whose data is still pending.
        wr_blk0 = stall & (wr0_addr == hold_addr);
        wr_blk1 = stall & (wr1_addr == hold_addr);
        wr_el0  = wr0_req & ~wr_blk0 & ~rst;
        wr_el1  = wr1_req & ~wr_blk1 & ~rst;
        wr0_gnt = wr_el0 & (~wr_el1 | ~wr_ptr);
        wr1_gnt = wr_el1 & (~wr_el0 | wr_ptr);
        ram_we  = wr0_gnt | wr1_gnt;
        ram_wa  = wr1_gnt ? wr1_addr : wr0_addr;
        ram_di  = wr1_gnt ? wr1_data : wr0_data;
    end

    // Arbiter pointers and read response tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_id    <= 1'b0;
            hold_addr <= '0;
        end else begin
            rsp_vld <= ram_re | stall;
            if (ram_re) begin
                rsp_id    <= rd1_gnt;
                hold_addr <= ram_ra;
                rd_ptr    <= ~rd1_gnt;
            end
            if (ram_we) begin
                wr_ptr <= ~wr1_gnt;
            end
        end
    end

`ifdef SA_RAM_ARB_PERF_EN
    logic [1:0]  stall_inc;
    logic [32:0] stall_sum;

    // Stall events: one per stalled cycle plus one per write-protected request.
    always_comb begin
        stall_inc = 2'(stall) + 2'(wr0_req & wr_blk0) + 2'(wr1_req & wr_blk1);
        stall_sum = {1'b0, perf_stall_cnt} + 33'(stall_inc);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (ram_re && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if (ram_we && (perf_wr_cnt != 32'hFFFF_FFFF)) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
            perf_stall_cnt <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_sa_ram_rws_arb_ctrl.sv
// Directed bench for sa_ram_rws_arb_ctrl with a behavioural model of the RAM
// macro (registered read address, combinational read data).
`timescale 1ns/1ps
module tb_sa_ram_rws_arb_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 512;

    localparam logic [DW-1:0] DA = {16{32'hAAAA_0001}};
    localparam logic [DW-1:0] DB = {16{32'hBBBB_0002}};
    localparam logic [DW-1:0] DC = {16{32'hCCCC_0003}};
    localparam logic [DW-1:0] DD = {16{32'hDDDD_0004}};
    localparam logic [DW-1:0] DE = {16{32'hEEEE_0005}};
    localparam logic [DW-1:0] DF = {16{32'hFFFF_0006}};
    localparam logic [DW-1:0] DG = {16{32'h1234_0007}};

    logic          clk = 1'b0;
    logic          rst;
    logic          rd0_req, rd1_req, rd0_gnt, rd1_gnt;
    logic [AW-1:0] rd0_addr, rd1_addr;
    logic          wr0_req, wr1_req, wr0_gnt, wr1_gnt;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          rsp_vld, rsp_rdy, rsp_id;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] ram_ra, ram_wa;
    logic          ram_re, ram_we;
    logic [DW-1:0] ram_di, ram_dout;
`ifdef SA_RAM_ARB_PERF_EN
    logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] mem [256];
    logic [AW-1:0] ra_d;

    always #5 clk = ~clk;

    // RAM macro model.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
    end
    assign ram_dout = mem[ra_d];

    sa_ram_rws_arb_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
`ifdef SA_RAM_ARB_PERF_EN
        .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .ram_dout(ram_dout)
    );

    task automatic clear_reqs();
        rd0_req = 1'b0; rd1_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rd0_req = 1'b1; rd1_req = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
        #1;
        total++; if (rsp_vld !== 1'b0) $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); else passed++;
        total++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); else passed++;
        total++; if ({rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt} !== 4'b0000)
            $display("FAIL reset_gnts got=%b exp=0000", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt}); else passed++;
        total++; if ({ram_re, ram_we} !== 2'b00)
            $display("FAIL reset_ram_en got=%b exp=00", {ram_re, ram_we}); else passed++;
        @(negedge clk);
        clear_reqs();
        rst = 1'b0;
    endtask

    task automatic test_rd_rr();
        @(negedge clk);
        rsp_rdy = 1'b1;
        rd0_req = 1'b1; rd0_addr = 8'h01;
        rd1_req = 1'b1; rd1_addr = 8'h02;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++; if ({rd0_gnt, rd1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL rr_rd_gnt[%0d] got=%b exp=%b", i, {rd0_gnt, rd1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            else passed++;
            @(posedge clk); #1;
            total++; if (rsp_vld !== 1'b1 || rsp_id !== 1'(i % 2))
                $display("FAIL rr_rsp[%0d] got vld=%b id=%b exp vld=1 id=%0d", i, rsp_vld, rsp_id, i % 2);
            else passed++;
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_wr_rr();
        @(negedge clk);
        wr0_req = 1'b1; wr0_addr = 8'h2A; wr0_data = DA;
        wr1_req = 1'b1; wr1_addr = 8'h2B; wr1_data = DB;
        #1;
        total++; if ({wr0_gnt, wr1_gnt, ram_we} !== 3'b101 || ram_wa !== 8'h2A || ram_di !== DA)
            $display("FAIL wr_rr_c1 got gnt=%b we=%b wa=%h exp gnt=10 we=1 wa=2a", {wr0_gnt, wr1_gnt}, ram_we, ram_wa);
        else passed++;
        @(negedge clk);
        wr0_req = 1'b0;
        #1;
        total++; if ({wr0_gnt, wr1_gnt} !== 2'b01 || ram_wa !== 8'h2B || ram_di !== DB)
            $display("FAIL wr_rr_c2 got gnt=%b wa=%h exp gnt=01 wa=2b", {wr0_gnt, wr1_gnt}, ram_wa);
        else passed++;
        @(negedge clk);
        wr1_req = 1'b0;
        rd0_req = 1'b1; rd0_addr = 8'h2A;
        @(posedge clk); #1;
        total++; if (rsp_data !== DA) $display("FAIL rd_2a got=%h exp=%h", rsp_data[31:0], DA[31:0]); else passed++;
        @(negedge clk);
        rd0_addr = 8'h2B;
        @(posedge clk); #1;
        total++; if (rsp_data !== DB) $display("FAIL rd_2b got=%h exp=%h", rsp_data[31:0], DB[31:0]); else passed++;
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        wr0_req = 1'b1; wr0_addr = 8'h10; wr0_data = DD;
        @(negedge clk);
        wr0_data = DC;
        rd0_req = 1'b1; rd0_addr = 8'h10;
        #1;
        total++; if ({rd0_gnt, wr0_gnt} !== 2'b11)
            $display("FAIL same_addr_gnt got=%b exp=11", {rd0_gnt, wr0_gnt}); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_vld !== 1'b1 || rsp_data !== DC)
            $display("FAIL same_addr_data got vld=%b data=%h exp vld=1 data=%h", rsp_vld, rsp_data[31:0], DC[31:0]);
        else passed++;
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_stall();
        @(negedge clk);
        rsp_rdy = 1'b1;
        wr0_req = 1'b1; wr0_addr = 8'h05; wr0_data = DE;
        @(negedge clk);
        wr0_req = 1'b0;
        rd0_req = 1'b1; rd0_addr = 8'h05;
        @(posedge clk); #1;
        total++; if (rsp_vld !== 1'b1 || rsp_data !== DE)
            $display("FAIL stall_first got vld=%b data=%h exp vld=1 data=%h", rsp_vld, rsp_data[31:0], DE[31:0]);
        else passed++;
        @(negedge clk);
        rd0_req = 1'b0; rsp_rdy = 1'b0;
        rd1_req = 1'b1; rd1_addr = 8'h07;
        wr0_req = 1'b1; wr0_addr = 8'h05; wr0_data = DF;
        wr1_req = 1'b1; wr1_addr = 8'h06; wr1_data = DG;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({wr0_gnt, wr1_gnt} !== ((i == 0) ? 2'b01 : 2'b00))
                $display("FAIL stall_wr_gnt[%0d] got=%b exp=%b", i, {wr0_gnt, wr1_gnt}, (i == 0) ? 2'b01 : 2'b00);
            else passed++;
            total++; if (rd1_gnt !== 1'b0 || ram_re !== 1'b0)
                $display("FAIL stall_rd_gnt[%0d] got gnt=%b re=%b exp 0 0", i, rd1_gnt, ram_re); else passed++;
            total++; if (rsp_vld !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== DE)
                $display("FAIL stall_hold[%0d] got vld=%b id=%b data=%h exp vld=1 id=0 data=%h",
                         i, rsp_vld, rsp_id, rsp_data[31:0], DE[31:0]);
            else passed++;
            @(posedge clk);
            @(negedge clk);
            wr1_req = 1'b0;
        end
        rsp_rdy = 1'b1;
        #1;
        total++; if ({wr0_gnt, rd1_gnt} !== 2'b11)
            $display("FAIL stall_release_gnt got wr0/rd1=%b exp=11", {wr0_gnt, rd1_gnt}); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_vld !== 1'b1 || rsp_id !== 1'b1)
            $display("FAIL stall_release_rsp got vld=%b id=%b exp vld=1 id=1", rsp_vld, rsp_id); else passed++;
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rsp_rdy = 1'b1;
        rd0_req = 1'b1; rd0_addr = 8'h03;
        wr0_req = 1'b1; wr0_addr = 8'h20; wr0_data = DA;
        #1;
        total++; if ({rd0_gnt, wr0_gnt} !== 2'b11)
            $display("FAIL rstmid_pre_gnt got=%b exp=11", {rd0_gnt, wr0_gnt}); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_vld !== 1'b1) $display("FAIL rstmid_pre_vld got=%b exp=1", rsp_vld); else passed++;
        @(negedge clk);
        rd1_req = 1'b1; rd1_addr = 8'h04;
        wr1_req = 1'b1; wr1_addr = 8'h21; wr1_data = DB;
        rst = 1'b1;
        #1;
        total++; if (rsp_vld !== 1'b0) $display("FAIL rstmid_vld got=%b exp=0", rsp_vld); else passed++;
        total++; if ({rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt, ram_re, ram_we} !== 6'b0)
            $display("FAIL rstmid_gnts got=%b exp=000000", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt, ram_re, ram_we});
        else passed++;
        @(posedge clk); #1;
        total++; if ({rsp_vld, rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt} !== 5'b0)
            $display("FAIL rstmid_hold got=%b exp=00000", {rsp_vld, rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt} !== 4'b1010 || rsp_vld !== 1'b0)
            $display("FAIL rstmid_ptr got gnts=%b vld=%b exp gnts=1010 vld=0", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt}, rsp_vld);
        else passed++;
        @(negedge clk);
        clear_reqs();
    endtask

`ifdef SA_RAM_ARB_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rsp_rdy = 1'b1;
        rd0_req = 1'b1; rd0_addr = 8'h01;
        wr0_req = 1'b1; wr0_addr = 8'h30; wr0_data = DA;
        @(negedge clk);
        wr0_req = 1'b0;
        wr1_req = 1'b1; wr1_addr = 8'h31; wr1_data = DB;
        @(negedge clk);
        wr1_req = 1'b0;
        @(negedge clk);
        rd0_req = 1'b0; rsp_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (perf_rd_cnt !== 32'd3) $display("FAIL perf_rd got=%0d exp=3", perf_rd_cnt); else passed++;
        total++; if (perf_wr_cnt !== 32'd2) $display("FAIL perf_wr got=%0d exp=2", perf_wr_cnt); else passed++;
        total++; if (perf_stall_cnt !== 32'd4) $display("FAIL perf_stall got=%0d exp=4", perf_stall_cnt); else passed++;
        @(negedge clk);
        rsp_rdy = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ra_d = '0;
        rst = 1'b1; rsp_rdy = 1'b0;
        clear_reqs();
        rd0_addr = '0; rd1_addr = '0; wr0_addr = '0; wr1_addr = '0;
        wr0_data = '0; wr1_data = '0;
        test_reset();
        test_rd_rr();
        test_wr_rr();
        test_same_addr();
        test_stall();
        test_reset_mid();
`ifdef SA_RAM_ARB_PERF_EN
        test_perf();
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
